// File: rtl/a2d_multi_seq.sv
// Multi-slot A2D scanner: SPI master to an external converter that steps through a
// programmable channel list, one slot per request or free-running, with optional
// per-slot IIR smoothing of the returned 12-bit samples.
module a2d_multi_seq #(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned SCLK_DIV   = 32,
  parameter int unsigned FILT_SHIFT = 0,
  parameter int unsigned GAP        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  nxt,
  input  logic [3*NUM_CH-1:0]   ch_map,
  input  logic                  MISO,
  output logic                  SS_n,
  output logic                  SCLK,
  output logic                  MOSI,
  output logic [12*NUM_CH-1:0]  results,
  output logic [NUM_CH-1:0]     rdy,
  output logic [NUM_CH-1:0]     valid,
  output logic                  busy,
  output logic [2:0]            cur_slot
);

  localparam int unsigned HALF      = SCLK_DIV / 2;
  localparam logic [15:0] HALF_END  = 16'(HALF - 1);
  localparam logic [15:0] GAP_END   = 16'(GAP - 1);
  localparam logic [2:0]  LAST_SLOT = 3'(NUM_CH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFront,
    StShift,
    StGap,
    StUpdate
  } state_t;

  state_t      state;
  logic [15:0] cnt;       // clk cycles within the current phase
  logic [3:0]  bit_cnt;   // SCLK period index within a frame
  logic        frame;     // 0 = command frame, 1 = data frame
  logic [15:0] tx;        // outgoing command, MSB first
  logic [11:0] rx;        // last 12 MISO bits; after frame 2 this is the sample
  logic [11:0] res [NUM_CH];

  logic [2:0]  next_slot;
  logic [2:0]  cur_ch;
  logic [2:0]  next_ch;
  logic [11:0] cur_res;
  logic        cur_valid;
  logic signed [12:0] diff;
  logic signed [12:0] step;
  logic [11:0] filt;
  logic [11:0] upd_val;

  // Slot bookkeeping: channel and stored result for the current and following slot
  always_comb begin
    cur_ch    = '0;
    next_ch   = '0;
    cur_res   = '0;
    cur_valid = 1'b0;
    next_slot = (cur_slot == LAST_SLOT) ? 3'd0 : cur_slot + 3'd1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cur_slot == 3'(k)) begin
        cur_ch    = ch_map[3*k +: 3];
        cur_res   = res[k];
        cur_valid = valid[k];
      end
      if (next_slot == 3'(k)) begin
        next_ch = ch_map[3*k +: 3];
      end
    end
  end

  // IIR step: r + ((s - r) >>> FILT_SHIFT); the sum always lands back in 0..4095
  assign diff    = $signed({1'b0, rx}) - $signed({1'b0, cur_res});
  assign step    = diff >>> FILT_SHIFT;
  assign filt    = 12'($signed({1'b0, cur_res}) + step);
  assign upd_val = ((FILT_SHIFT == 0) || !cur_valid) ? rx : filt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_results
    assign results[12*g +: 12] = res[g];
  end

  // Conversion sequencer: SPI framing, slot stepping and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      cnt      <= '0;
      bit_cnt  <= '0;
      frame    <= 1'b0;
      tx       <= '0;
      rx       <= '0;
      SS_n     <= 1'b1;
      SCLK     <= 1'b1;
      MOSI     <= 1'b0;
      rdy      <= '0;
      valid    <= '0;
      busy     <= 1'b0;
      cur_slot <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        res[k] <= '0;
      end
    end else begin
      rdy <= '0;
      unique case (state)
        StIdle: begin
          if (mode || nxt) begin
            // ch_map is captured here and held in tx for the whole conversion
            state   <= StFront;
            SS_n    <= 1'b0;
            SCLK    <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
            frame   <= 1'b0;
            tx      <= {2'b00, cur_ch, 11'h000};
            busy    <= 1'b1;
          end
        end

        StFront: begin
          if (cnt == HALF_END) begin
            state <= StShift;
            cnt   <= '0;
            SCLK  <= 1'b0;
            MOSI  <= tx[15];
            tx    <= {tx[14:0], 1'b0};
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        StShift: begin
          if (cnt == HALF_END) begin
            cnt <= '0;
            if (!SCLK) begin
              // Rising SCLK: sample MISO on this same clk edge
              SCLK <= 1'b1;
              rx   <= {rx[10:0], MISO};
            end else if (bit_cnt == 4'd15) begin
              state <= StGap;
              SS_n  <= 1'b1;
              MOSI  <= 1'b0;
            end else begin
              SCLK    <= 1'b0;
              MOSI    <= tx[15];
              tx      <= {tx[14:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        StGap: begin
          if (cnt == GAP_END) begin
            cnt <= '0;
            if (!frame) begin
              state   <= StFront;
              frame   <= 1'b1;
              SS_n    <= 1'b0;
              bit_cnt <= '0;
              tx      <= '0;
            end else begin
              state <= StUpdate;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        StUpdate: begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (cur_slot == 3'(k)) begin
              res[k]   <= upd_val;
              rdy[k]   <= 1'b1;
              valid[k] <= 1'b1;
            end
          end
          cur_slot <= next_slot;
          if (mode) begin
            // Continuous scan: go straight into the next slot's command frame
            state   <= StFront;
            SS_n    <= 1'b0;
            SCLK    <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
            frame   <= 1'b0;
            tx      <= {2'b00, next_ch, 11'h000};
          end else begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_multi_seq.sv
// Self-checking bench for a2d_multi_seq: two instances (default 3-slot scanner and a
// fast 1-slot filtered variant), each driven by a small A2D slave model.
`timescale 1ns/1ps
module tb_a2d_multi_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance A: NUM_CH=3, SCLK_DIV=32, no filter, GAP=2
  logic        a_mode, a_nxt, a_ss_n, a_sclk, a_mosi, a_busy;
  logic        a_miso = 1'b0;
  logic [8:0]  a_ch_map;
  logic [35:0] a_results;
  logic [2:0]  a_rdy, a_valid, a_cur_slot;

  a2d_multi_seq #(.NUM_CH(3), .SCLK_DIV(32), .FILT_SHIFT(0), .GAP(2)) dut_a (
    .clk(clk), .rst(rst), .mode(a_mode), .nxt(a_nxt), .ch_map(a_ch_map), .MISO(a_miso),
    .SS_n(a_ss_n), .SCLK(a_sclk), .MOSI(a_mosi), .results(a_results), .rdy(a_rdy),
    .valid(a_valid), .busy(a_busy), .cur_slot(a_cur_slot)
  );

  // Instance B: NUM_CH=1, SCLK_DIV=4, FILT_SHIFT=2, GAP=1
  logic        b_mode, b_nxt, b_ss_n, b_sclk, b_mosi, b_busy;
  logic        b_miso = 1'b0;
  logic [2:0]  b_ch_map;
  logic [11:0] b_results;
  logic [0:0]  b_rdy, b_valid;
  logic [2:0]  b_cur_slot;

  a2d_multi_seq #(.NUM_CH(1), .SCLK_DIV(4), .FILT_SHIFT(2), .GAP(1)) dut_b (
    .clk(clk), .rst(rst), .mode(b_mode), .nxt(b_nxt), .ch_map(b_ch_map), .MISO(b_miso),
    .SS_n(b_ss_n), .SCLK(b_sclk), .MOSI(b_mosi), .results(b_results), .rdy(b_rdy),
    .valid(b_valid), .busy(b_busy), .cur_slot(b_cur_slot)
  );

  // A2D slave models: MISO changes after SCLK falls, MOSI captured after SCLK rises
  logic [11:0] a_sample, b_sample;
  logic [15:0] a_sh_out, a_mosi_sh, a_last_cmd, b_sh_out, b_mosi_sh, b_last_cmd;
  logic        a_frame = 1'b0, a_ss_d = 1'b1, a_sclk_d = 1'b1;
  logic        b_frame = 1'b0, b_ss_d = 1'b1, b_sclk_d = 1'b1;
  int          a_rises, a_last_rises, b_rises;

  always @(posedge clk) begin
    if (rst) begin
      a_frame = 1'b0; a_ss_d = 1'b1; a_sclk_d = 1'b1;
    end else begin
      if (a_ss_d && !a_ss_n) begin
        a_sh_out = a_frame ? {4'hB, a_sample} : 16'hD5A3;
        a_rises  = 0;
      end
      if (!a_ss_n && a_sclk_d && !a_sclk) begin
        a_miso   <= a_sh_out[15];
        a_sh_out = {a_sh_out[14:0], 1'b0};
      end
      if (!a_ss_n && !a_sclk_d && a_sclk) begin
        a_mosi_sh = {a_mosi_sh[14:0], a_mosi};
        a_rises++;
      end
      if (!a_ss_d && a_ss_n) begin
        if (!a_frame) a_last_cmd = a_mosi_sh;
        a_last_rises = a_rises;
        a_frame = ~a_frame;
      end
      a_ss_d = a_ss_n; a_sclk_d = a_sclk;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      b_frame = 1'b0; b_ss_d = 1'b1; b_sclk_d = 1'b1;
    end else begin
      if (b_ss_d && !b_ss_n) begin
        b_sh_out = b_frame ? {4'h7, b_sample} : 16'h9C3E;
        b_rises  = 0;
      end
      if (!b_ss_n && b_sclk_d && !b_sclk) begin
        b_miso   <= b_sh_out[15];
        b_sh_out = {b_sh_out[14:0], 1'b0};
      end
      if (!b_ss_n && !b_sclk_d && b_sclk) begin
        b_mosi_sh = {b_mosi_sh[14:0], b_mosi};
        b_rises++;
      end
      if (!b_ss_d && b_ss_n) begin
        if (!b_frame) b_last_cmd = b_mosi_sh;
        b_frame = ~b_frame;
      end
      b_ss_d = b_ss_n; b_sclk_d = b_sclk;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_a_nxt();
    a_nxt = 1'b1; @(negedge clk); a_nxt = 1'b0;
  endtask

  task automatic pulse_b_nxt();
    b_nxt = 1'b1; @(negedge clk); b_nxt = 1'b0;
  endtask

  task automatic wait_rdy_a(input int limit, output logic [2:0] seen, output int cyc);
    seen = '0; cyc = 0;
    while (cyc < limit && seen == 3'b000) begin
      @(negedge clk); cyc++;
      seen = a_rdy;
    end
  endtask

  task automatic wait_rdy_b(input int limit, output logic seen, output int cyc);
    seen = 1'b0; cyc = 0;
    while (cyc < limit && !seen) begin
      @(negedge clk); cyc++;
      seen = b_rdy[0];
    end
  endtask

  task automatic wait_ss_a(input logic lvl, input int limit, output int cyc);
    cyc = 0;
    while (a_ss_n !== lvl && cyc < limit) begin
      @(negedge clk); cyc++;
    end
  endtask

  // Count cycles with SS_n low or rdy set on A while it should sit idle
  task automatic idle_watch_a(input int n, output int lows, output int rdys);
    lows = 0; rdys = 0;
    repeat (n) begin
      @(negedge clk);
      if (!a_ss_n) lows++;
      if (a_rdy != 3'b000) rdys++;
    end
  endtask

  typedef struct {
    logic [11:0] sample;
    logic [2:0]  slot;
    logic [15:0] cmd;
    logic [2:0]  valid;
    logic [2:0]  next_slot;
  } trig_vec_t;

  typedef struct {
    logic        do_rst;
    logic [11:0] sample;
    logic [11:0] exp;
  } filt_vec_t;

  trig_vec_t tv [3];
  filt_vec_t fv [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] seen;
    logic       seen_b;
    int         cyc, lows, rdys;

    tv[0] = '{12'hA5C, 3'd0, 16'h0000, 3'b001, 3'd1};
    tv[1] = '{12'h123, 3'd1, 16'h0800, 3'b011, 3'd2};
    tv[2] = '{12'hFFF, 3'd2, 16'h2000, 3'b111, 3'd0};

    fv[0] = '{1'b0, 12'h400, 12'h400};
    fv[1] = '{1'b0, 12'h800, 12'h500};
    fv[2] = '{1'b0, 12'h800, 12'h5C0};
    fv[3] = '{1'b0, 12'h800, 12'h650};
    fv[4] = '{1'b1, 12'h004, 12'h004};
    fv[5] = '{1'b0, 12'h000, 12'h003};
    fv[6] = '{1'b0, 12'h000, 12'h002};

    rst = 1'b1;
    a_mode = 1'b0; a_nxt = 1'b0; a_ch_map = {3'd4, 3'd1, 3'd0}; a_sample = '0;
    b_mode = 1'b0; b_nxt = 1'b0; b_ch_map = 3'd5; b_sample = '0;
    tick(3);
    rst = 1'b0;

    // Reset state
    check("rst_ss_n", a_ss_n, 1'b1);
    check("rst_sclk", a_sclk, 1'b1);
    check("rst_mosi", a_mosi, 1'b0);
    check("rst_results", a_results, '0);
    check("rst_rdy", a_rdy, '0);
    check("rst_valid", a_valid, '0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_cur_slot", a_cur_slot, 3'd0);

    // Triggered scan over the three slots
    for (int i = 0; i < 3; i++) begin
      a_sample = tv[i].sample;
      pulse_a_nxt();
      check("trig_busy", a_busy, 1'b1);
      wait_rdy_a(1500, seen, cyc);
      if (i == 0) check("trig_latency", cyc, 1061);
      check("trig_rdy", seen, 3'b001 << tv[i].slot);
      check("trig_result", a_results[12*tv[i].slot +: 12], tv[i].sample);
      check("trig_cmd", a_last_cmd, tv[i].cmd);
      check("trig_valid", a_valid, tv[i].valid);
      check("trig_next_slot", a_cur_slot, tv[i].next_slot);
      check("trig_busy_done", a_busy, 1'b0);
      tick(1);
      check("trig_rdy_one_cycle", a_rdy, 3'b000);
    end
    check("trig_all_results", a_results, {12'hFFF, 12'h123, 12'hA5C});

    // Frame timing, and nxt while busy is dropped
    a_sample = 12'h777;
    pulse_a_nxt();
    wait_ss_a(1'b0, 20, cyc);
    check("timing_ss_fall", a_ss_n, 1'b0);
    wait_ss_a(1'b1, 1000, cyc);
    check("timing_ss_low_cycles", cyc, 528);
    wait_ss_a(1'b0, 100, cyc);
    check("timing_gap_cycles", cyc, 2);
    check("timing_sclk_rises", a_last_rises, 16);
    tick(50);
    pulse_a_nxt();
    wait_rdy_a(1500, seen, cyc);
    check("timing_rdy", seen, 3'b001);
    check("timing_result", a_results[11:0], 12'h777);
    idle_watch_a(1200, lows, rdys);
    check("busy_nxt_ignored_ss", lows, 0);
    check("busy_nxt_ignored_rdy", rdys, 0);
    check("busy_nxt_cur_slot", a_cur_slot, 3'd1);

    // Reset during SHIFT of frame 2
    a_sample = 12'h456;
    pulse_a_nxt();
    wait_ss_a(1'b1, 1000, cyc);
    wait_ss_a(1'b0, 100, cyc);
    tick(200);
    check("midrst_in_frame", a_ss_n, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ss_n", a_ss_n, 1'b1);
    check("midrst_sclk", a_sclk, 1'b1);
    check("midrst_results", a_results, '0);
    check("midrst_valid", a_valid, '0);
    check("midrst_cur_slot", a_cur_slot, 3'd0);
    check("midrst_busy", a_busy, 1'b0);
    check("midrst_rdy", a_rdy, '0);
    idle_watch_a(1200, lows, rdys);
    check("midrst_no_rdy", rdys, 0);
    check("midrst_no_frame", lows, 0);

    // Continuous scan, then drop mode mid-conversion
    a_sample = 12'h3C3;
    a_mode = 1'b1;
    for (int k = 0; k < 7; k++) begin
      wait_rdy_a(1500, seen, cyc);
      check("cont_slot", seen, 3'b001 << (k % 3));
      check("cont_busy", a_busy, 1'b1);
      check("cont_result", a_results[12*(k % 3) +: 12], 12'h3C3);
      if (k > 0) check("cont_period", cyc, 1061);
    end
    tick(100);
    a_mode = 1'b0;
    wait_rdy_a(1500, seen, cyc);
    check("cont_last_slot", seen, 3'b010);
    check("cont_stop_busy", a_busy, 1'b0);
    idle_watch_a(1200, lows, rdys);
    check("cont_stopped", lows, 0);

    // Filtered single-slot instance
    for (int i = 0; i < 7; i++) begin
      if (fv[i].do_rst) begin
        rst = 1'b1; tick(2); rst = 1'b0;
        check("filt_reset", b_results, 12'h000);
      end
      b_sample = fv[i].sample;
      pulse_b_nxt();
      wait_rdy_b(400, seen_b, cyc);
      if (i == 0) check("filt_latency", cyc, 135);
      check("filt_rdy", seen_b, 1'b1);
      check("filt_result", b_results, fv[i].exp);
      check("filt_cur_slot", b_cur_slot, 3'd0);
      check("filt_valid", b_valid, 1'b1);
      check("filt_cmd", b_last_cmd, 16'h2800);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/a2d_multi_seq.md
Name: a2d_multi_seq

Overview:
Parametrised successor to the single-purpose A2D interface used for the lft_ld/rght_ld/batt readings. It runs an SPI master to the external A2D converter and scans a programmable list of NUM_CH converter channels, either one slot per nxt request or free-running. Each slot has its own result register with an optional IIR smoothing filter. It sits between the A2D pins (SS_n/SCLK/MOSI/MISO) and the digital core.

Parameters:
NUM_CH, 3, number of scan slots (1..8)
SCLK_DIV, 32, clk cycles per SCLK period (even, >=4)
FILT_SHIFT, 0, IIR shift per slot update; 0 = raw samples, no filtering
GAP, 2, SS_n-high clk cycles between frames (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
mode  in  1  0 = triggered (nxt), 1 = continuous scan
nxt  in  1  one-cycle request: convert current slot (mode 0 only)
ch_map  in  3*NUM_CH  A2D channel number for each slot; slot k = bits [3k+2:3k]
MISO  in  1  serial data from A2D
SS_n  out  1  A2D slave select, active low
SCLK  out  1  serial clock, idle high
MOSI  out  1  serial command to A2D
results  out  12*NUM_CH  per-slot result; slot k = bits [12k+11:12k]
rdy  out  NUM_CH  one-cycle strobe, bit k set when results slot k updates
valid  out  NUM_CH  sticky; bit k set after first update of slot k
busy  out  1  conversion in progress
cur_slot  out  3  slot to be converted next, or being converted

Behaviour:
- Reset (rst=1 on a clk edge; overrides everything, aborts any transfer): SS_n=1, SCLK=1, MOSI=0, results=0, rdy=0, valid=0, busy=0, cur_slot=0, state IDLE.
- Conversion = two 16-bit SPI frames. Frame 1 shifts out command {2'b00, ch_map[cur_slot], 11'h000} MSB-first; its MISO data is discarded. Frame 2 shifts out 16'h0000; the low 12 bits of its MISO word are the sample.
- Frame timing: SS_n falls; SCLK stays high for SCLK_DIV/2 cycles (front porch). Then 16 periods, each SCLK low for SCLK_DIV/2 cycles, then high for SCLK_DIV/2 cycles. MOSI changes on the SCLK falling transition. MISO is sampled on the clk edge where SCLK rises. SS_n rises at the end of the 16th high phase. Frame length = 16*SCLK_DIV + SCLK_DIV/2 cycles (528 at default). SS_n then stays high GAP cycles.
- FSM: IDLE -> FRONT -> SHIFT -> GAP, traversed twice (frame flag 0/1), then UPDATE -> IDLE, or -> FRONT when mode=1.
- busy is 1 from the cycle after start through UPDATE inclusive.
- Start conditions:
  - mode 0: start on nxt=1 in IDLE. nxt while busy is ignored, not queued.
  - mode 1: start from IDLE automatically; in UPDATE, continue directly to FRONT of the next slot.
- Mode changes are sampled only in UPDATE and IDLE; the current conversion always completes.
- UPDATE (1 cycle), with s = sample and r = results[cur_slot]:
  - If FILT_SHIFT=0 or valid[cur_slot]=0: r <= s.
  - Otherwise: r <= r + ((s - r) >>> FILT_SHIFT), computed signed in 13 bits and truncated to 12 (the result never leaves 0..4095).
  - Same cycle: rdy[cur_slot]=1, valid[cur_slot]<=1, cur_slot <= (cur_slot==NUM_CH-1) ? 0 : cur_slot+1.
- ch_map is sampled at the start of frame 1; changes mid-conversion do not affect that conversion.
- End-to-end latency, nxt to rdy: 1 + 2*(528+GAP) cycles at default.

Test Plan:
- Reset mid-frame: assert rst during SHIFT of frame 2 -> next cycle SS_n=1, SCLK=1, results=0, valid=0, cur_slot=0; no rdy pulse.
- Triggered scan, NUM_CH=3, ch_map={3'd4,3'd1,3'd0}, model returns 12'hA5C/12'h123/12'hFFF: three nxt pulses -> frame-1 MOSI words 16'h0000, 16'h0800, 16'h2000; results slots 0..2 = A5C/123/FFF; rdy bits 0,1,2 in order; cur_slot wraps to 0.
- Timing: measure one frame at SCLK_DIV=32 -> SS_n low exactly 528 cycles, 16 SCLK rises, SS_n high exactly GAP=2 cycles between frames; nxt pulsed while busy -> no extra conversion.
- Continuous mode: mode=1 for 7 conversions -> slot order 0,1,2,0,1,2,0 with no IDLE gaps; drop mode to 0 mid-conversion -> that conversion completes, then busy=0.
- Filter, FILT_SHIFT=2, constant sample 12'h400: first update -> 12'h400. Then sample 12'h800 -> 12'h500, 12'h5C0, 12'h650. Sample 12'h000 from 12'h004 -> 12'h003; no underflow.
- NUM_CH=1 -> cur_slot stays 0 and every conversion updates slot 0.
